// File: rtl/hook_pkg.sv
// Shared types, widths and constant-geometry helpers for the hook trajectory controller.
// Arc geometry is computed at elaboration time so the angle ROM tracks NUM_ANGLES/LAUNCH_SPEED.
package hook_pkg;

  localparam int COORD_W  = 11;
  localparam int IDX_W    = 6;
  localparam int WEIGHT_W = 2;
  localparam int ARC_R    = 32;

  typedef enum logic [1:0] {
    SWING   = 2'd0,
    EXTEND  = 2'd1,
    RETRACT = 2'd2
  } hook_state_t;

  function automatic int isqrt(input int v);
    int r;
    r = 0;
    for (int unsigned i = 0; i <= ARC_R; i++) begin
      if (int'(i * i) <= v) r = int'(i);
    end
    return r;
  endfunction

  // X offset is linear in the index (truncated toward zero, so symmetric about the centre);
  // Y is then chosen to keep the point on the radius-32 circle.
  function automatic int arc_off_x(input int idx, input int n);
    int c;
    c = (n - 1) / 2;
    return (ARC_R * (idx - c)) / c;
  endfunction

  function automatic int arc_off_y(input int idx, input int n);
    int ox;
    ox = arc_off_x(idx, n);
    return isqrt(ARC_R * ARC_R - ox * ox);
  endfunction

  function automatic int dir_x(input int idx, input int n, input int speed);
    return (speed * arc_off_x(idx, n)) / ARC_R;
  endfunction

  function automatic int dir_y(input int idx, input int n, input int speed);
    int d;
    d = (speed * arc_off_y(idx, n)) / ARC_R;
    return (d < 1) ? 1 : d;
  endfunction

  function automatic logic signed [COORD_W-1:0] vel_shift(
    input logic signed [COORD_W-1:0] v,
    input logic        [WEIGHT_W-1:0] w
  );
    return v >>> w;
  endfunction

endpackage

// File: rtl/hook_angle_rom.sv
// Combinational arc ROM: angle index -> hook offset from pivot and launch direction vector.
module hook_angle_rom
  import hook_pkg::*;
#(
  parameter int NUM_ANGLES   = 51,
  parameter int LAUNCH_SPEED = 10
) (
  input  logic        [IDX_W-1:0]   idx,
  output logic signed [COORD_W-1:0] offX,
  output logic signed [COORD_W-1:0] offY,
  output logic signed [COORD_W-1:0] dirX,
  output logic signed [COORD_W-1:0] dirY
);

  logic signed [COORD_W-1:0] tab_ox [NUM_ANGLES];
  logic signed [COORD_W-1:0] tab_oy [NUM_ANGLES];
  logic signed [COORD_W-1:0] tab_dx [NUM_ANGLES];
  logic signed [COORD_W-1:0] tab_dy [NUM_ANGLES];

  for (genvar g = 0; g < NUM_ANGLES; g++) begin : g_tab
    assign tab_ox[g] = COORD_W'(arc_off_x(g, NUM_ANGLES));
    assign tab_oy[g] = COORD_W'(arc_off_y(g, NUM_ANGLES));
    assign tab_dx[g] = COORD_W'(dir_x(g, NUM_ANGLES, LAUNCH_SPEED));
    assign tab_dy[g] = COORD_W'(dir_y(g, NUM_ANGLES, LAUNCH_SPEED));
  end

  always_comb begin
    offX = '0;
    offY = '0;
    dirX = '0;
    dirY = '0;
    if (int'(idx) < NUM_ANGLES) begin
      offX = tab_ox[idx];
      offY = tab_oy[idx];
      dirX = tab_dx[idx];
      dirY = tab_dy[idx];
    end
  end

endmodule

// File: rtl/hook_trajectory_ctrl.sv
// Claw hook swing/launch/retract controller. Optional HOOK_PAUSE_EN adds a 'pause' input
// that masks startOfFrame (motion and swing divider freeze; collision still retracts).
module hook_trajectory_ctrl
  import hook_pkg::*;
#(
  parameter int PIVOT_X      = 288,
  parameter int PIVOT_Y      = 64,
  parameter int NUM_ANGLES   = 51,
  parameter int SWING_DIV    = 4,
  parameter int LAUNCH_SPEED = 10,
  parameter int X_MAX        = 639,
  parameter int Y_MAX        = 479,
  parameter int OBJ_W        = 64
) (
  input  logic                clk,
  input  logic                resetN,
  input  logic                startOfFrame,
  input  logic                launch_Cable,
  input  logic                collision,
  input  logic [WEIGHT_W-1:0] load_weight,
`ifdef HOOK_PAUSE_EN
  input  logic                pause,
`endif
  output logic [COORD_W-1:0]  topLeftX,
  output logic [COORD_W-1:0]  topLeftY,
  output logic [IDX_W-1:0]    angleIdx,
  output logic [1:0]          hookState,
  output logic                isSwinging,
  output logic                hookReturned,
  output logic [WEIGHT_W-1:0] grabbedWeight
);

  localparam logic signed [COORD_W-1:0] PX    = COORD_W'(PIVOT_X);
  localparam logic signed [COORD_W-1:0] PY    = COORD_W'(PIVOT_Y);
  localparam logic signed [COORD_W-1:0] X_LIM = COORD_W'(X_MAX - OBJ_W);
  localparam logic signed [COORD_W-1:0] Y_LIM = COORD_W'(Y_MAX);
  localparam logic signed [COORD_W-1:0] RST_X = COORD_W'(PIVOT_X + arc_off_x(0, NUM_ANGLES));
  localparam logic signed [COORD_W-1:0] RST_Y = COORD_W'(PIVOT_Y + arc_off_y(0, NUM_ANGLES));
  localparam logic signed [COORD_W-1:0] ONE   = COORD_W'(1);
  localparam logic [IDX_W-1:0]          LAST_IDX = IDX_W'(NUM_ANGLES - 1);
  localparam logic [3:0]                DIV_LAST = 4'(SWING_DIV - 1);

  hook_state_t               state;
  logic [IDX_W-1:0]          idx;
  logic                      dir_up;
  logic [3:0]                div_cnt;
  logic signed [COORD_W-1:0] pos_x, pos_y, vel_x, vel_y;
  logic                      returned;
  logic [WEIGHT_W-1:0]       weight;

  logic signed [COORD_W-1:0] off_x, off_y, dv_x, dv_y;
  logic signed [COORD_W-1:0] arc_x, arc_y, step_x, step_y_raw, step_y, ret_x, ret_y;
  logic                      frame_tick, oob, arrive;
  logic [IDX_W-1:0]          idx_next;
  logic                      dir_next;

  hook_angle_rom #(
    .NUM_ANGLES  (NUM_ANGLES),
    .LAUNCH_SPEED(LAUNCH_SPEED)
  ) u_rom (
    .idx (idx),
    .offX(off_x),
    .offY(off_y),
    .dirX(dv_x),
    .dirY(dv_y)
  );

`ifdef HOOK_PAUSE_EN
  assign frame_tick = startOfFrame & ~pause;
`else
  assign frame_tick = startOfFrame;
`endif

  // Retract step is the launch velocity scaled down by load weight; Y never stalls at 0.
  always_comb begin
    arc_x      = PX + off_x;
    arc_y      = PY + off_y;
    step_x     = vel_shift(vel_x, weight);
    step_y_raw = vel_shift(vel_y, weight);
    step_y     = (step_y_raw == '0) ? ONE : step_y_raw;
    ret_x      = pos_x - step_x;
    ret_y      = pos_y - step_y;
    arrive     = (ret_y <= arc_y);
    oob        = (pos_x < 0) || (pos_x > X_LIM) || (pos_y > Y_LIM);
  end

  always_comb begin
    idx_next = idx;
    dir_next = dir_up;
    if (dir_up) begin
      if (idx == LAST_IDX) begin
        dir_next = 1'b0;
        idx_next = LAST_IDX - 1'b1;
      end else begin
        idx_next = idx + 1'b1;
      end
    end else begin
      if (idx == '0) begin
        dir_next = 1'b1;
        idx_next = IDX_W'(1);
      end else begin
        idx_next = idx - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state    <= SWING;
      idx      <= '0;
      dir_up   <= 1'b1;
      div_cnt  <= '0;
      pos_x    <= RST_X;
      pos_y    <= RST_Y;
      vel_x    <= '0;
      vel_y    <= '0;
      returned <= 1'b0;
      weight   <= '0;
    end else begin
      returned <= 1'b0;
      case (state)
        SWING: begin
          if (launch_Cable) begin
            state   <= EXTEND;
            vel_x   <= dv_x;
            vel_y   <= dv_y;
            div_cnt <= '0;
          end else if (frame_tick) begin
            pos_x <= arc_x;
            pos_y <= arc_y;
            if (div_cnt == DIV_LAST) begin
              div_cnt <= '0;
              idx     <= idx_next;
              dir_up  <= dir_next;
            end else begin
              div_cnt <= div_cnt + 1'b1;
            end
          end
        end
        EXTEND: begin
          if (collision) begin
            state  <= RETRACT;
            weight <= load_weight;
          end else if (oob) begin
            state  <= RETRACT;
            weight <= '0;
          end else if (frame_tick) begin
            pos_x <= pos_x + vel_x;
            pos_y <= pos_y + vel_y;
          end
        end
        RETRACT: begin
          if (frame_tick) begin
            if (arrive) begin
              pos_x    <= arc_x;
              pos_y    <= arc_y;
              state    <= SWING;
              returned <= 1'b1;
            end else begin
              pos_x <= ret_x;
              pos_y <= ret_y;
            end
          end
        end
        default: state <= SWING;
      endcase
    end
  end

  assign topLeftX      = pos_x;
  assign topLeftY      = pos_y;
  assign angleIdx      = idx;
  assign hookState     = state;
  assign isSwinging    = (state == SWING);
  assign hookReturned  = returned;
  assign grabbedWeight = weight;

endmodule

// File: tb/tb_hook_trajectory_ctrl.sv
// Scoreboard bench for hook_trajectory_ctrl: per-frame and per-return expectations are queued
// by the stimulus thread and compared by independent monitor threads.
module tb_hook_trajectory_ctrl;

  logic        clk = 1'b0;
  logic        resetN = 1'b1;
  logic        startOfFrame = 1'b0;
  logic        launch_Cable = 1'b0;
  logic        collision = 1'b0;
  logic [1:0]  load_weight = 2'd0;
`ifdef HOOK_PAUSE_EN
  logic        pause = 1'b0;
`endif
  logic [10:0] topLeftX, topLeftY;
  logic [5:0]  angleIdx;
  logic [1:0]  hookState, grabbedWeight;
  logic        isSwinging, hookReturned;

  int n_pass  = 0;
  int n_total = 0;
  int fno     = 0;

  typedef struct { bit cp; int x; int y; int idx; int st; } fexp_t;
  typedef struct { int x; int y; int w; } rexp_t;
  fexp_t fq[$];
  rexp_t rq[$];
  fexp_t fe;
  rexp_t re;

  always #5 clk = ~clk;

  hook_trajectory_ctrl #(
    .PIVOT_X(288), .PIVOT_Y(64), .NUM_ANGLES(51), .SWING_DIV(4),
    .LAUNCH_SPEED(10), .X_MAX(639), .Y_MAX(479), .OBJ_W(64)
  ) dut (
    .clk          (clk),
    .resetN       (resetN),
    .startOfFrame (startOfFrame),
    .launch_Cable (launch_Cable),
    .collision    (collision),
    .load_weight  (load_weight),
`ifdef HOOK_PAUSE_EN
    .pause        (pause),
`endif
    .topLeftX     (topLeftX),
    .topLeftY     (topLeftY),
    .angleIdx     (angleIdx),
    .hookState    (hookState),
    .isSwinging   (isSwinging),
    .hookReturned (hookReturned),
    .grabbedWeight(grabbedWeight)
  );

  function automatic void check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endfunction

  function automatic int swing_idx(input int k);
    int p;
    p = (k / 4) % 100;
    return (p <= 50) ? p : 100 - p;
  endfunction

  task automatic fr(input bit cp, input int x, input int y, input int idx, input int st,
                    input bit coll, input logic [1:0] w);
    fexp_t e;
    e.cp = cp; e.x = x; e.y = y; e.idx = idx; e.st = st;
    fq.push_back(e);
    startOfFrame = 1'b1;
    @(negedge clk);
    startOfFrame = 1'b0;
    collision    = coll;
    load_weight  = w;
    @(negedge clk);
    collision = 1'b0;
    @(negedge clk);
  endtask

  task automatic launch();
    launch_Cable = 1'b1;
    @(negedge clk);
    launch_Cable = 1'b0;
    @(negedge clk);
  endtask

  // Frame monitor: outputs settle two edges after the startOfFrame edge (covers OOB turnaround).
  initial begin
    forever begin
      @(posedge clk);
      if (startOfFrame) begin
        @(negedge clk);
        @(negedge clk);
        fno++;
        if (fq.size() == 0) begin
          n_total++;
          $display("FAIL frame_q: frame %0d seen, no expectation queued", fno);
        end else begin
          fe = fq.pop_front();
          if (fe.cp) begin
            check($sformatf("f%0d.x", fno), int'($signed(topLeftX)), fe.x);
            check($sformatf("f%0d.y", fno), int'($signed(topLeftY)), fe.y);
          end
          check($sformatf("f%0d.idx", fno), int'(angleIdx), fe.idx);
          check($sformatf("f%0d.state", fno), int'(hookState), fe.st);
          check($sformatf("f%0d.swinging", fno), int'(isSwinging), int'(fe.st == 0));
        end
      end
    end
  end

  // Return monitor: pulse content, then one-clock width.
  initial begin
    forever begin
      @(negedge clk);
      if (hookReturned) begin
        if (rq.size() == 0) begin
          n_total++;
          $display("FAIL returned: unexpected pulse at frame %0d, expected none", fno);
        end else begin
          re = rq.pop_front();
          check("ret.x", int'($signed(topLeftX)), re.x);
          check("ret.y", int'($signed(topLeftY)), re.y);
          check("ret.weight", int'(grabbedWeight), re.w);
        end
        @(negedge clk);
        check("ret.width", int'(hookReturned), 0);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int pi, px, py;
    #3 resetN = 1'b0;
    repeat (2) @(negedge clk);
    check("rst.x", int'($signed(topLeftX)), 256);
    check("rst.y", int'($signed(topLeftY)), 64);
    check("rst.idx", int'(angleIdx), 0);
    check("rst.state", int'(hookState), 0);
    check("rst.swinging", int'(isSwinging), 1);
    check("rst.returned", int'(hookReturned), 0);
    check("rst.weight", int'(grabbedWeight), 0);
    resetN = 1'b1;
    @(negedge clk);

    // Launch at idx 0: dir (-10,+1), leaves left edge on frame 26, returns at full speed.
    // Launch and collision during RETRACT must be ignored.
    launch();
    for (int n = 1; n <= 26; n++) fr(1, 256 - 10 * n, 64 + n, 0, (n == 26) ? 2 : 1, 0, 2'd0);
    for (int m = 1; m <= 25; m++) begin
      if (m == 10) launch();
      fr(1, -4 + 10 * m, 90 - m, 0, 2, (m == 12), 2'd2);
    end
    rq.push_back('{x: 256, y: 64, w: 0});
    fr(1, 256, 64, 0, 0, 0, 2'd0);

    // Swing: step every 4th frame, ping-pong at 50; position lags index by one frame.
    for (int k = 1; k <= 301; k++) begin
      pi = swing_idx(k - 1);
      px = (pi == 0) ? 256 : (pi == 25) ? 288 : 320;
      py = (pi == 25) ? 96 : 64;
      fr((pi == 0) || (pi == 25) || (pi == 50), px, py, swing_idx(k), 0, 0, 2'd0);
    end

    // Centre launch straight down, collision with weight 2, retract 2 px/frame.
    launch();
    for (int n = 1; n <= 5; n++) fr(1, 288, 96 + 10 * n, 25, 1, 0, 2'd0);
    fr(1, 288, 156, 25, 2, 1, 2'd2);
    for (int m = 1; m <= 29; m++) fr(1, 288, 156 - 2 * m, 25, 2, 0, 2'd0);
    rq.push_back('{x: 288, y: 96, w: 2});
    fr(1, 288, 96, 25, 0, 0, 2'd0);

    // Bottom exit coinciding with collision (weight 3): collision wins, retract 1 px/frame.
    launch();
    for (int n = 1; n <= 38; n++) fr(1, 288, 96 + 10 * n, 25, 1, 0, 2'd0);
    fr(1, 288, 486, 25, 2, 1, 2'd3);
    for (int m = 1; m <= 389; m++) fr(1, 288, 486 - m, 25, 2, 0, 2'd0);
    rq.push_back('{x: 288, y: 96, w: 3});
    fr(1, 288, 96, 25, 0, 0, 2'd0);

    // Asynchronous reset mid-EXTEND.
    launch();
    for (int n = 1; n <= 3; n++) fr(1, 288, 96 + 10 * n, 25, 1, 0, 2'd0);
    #2 resetN = 1'b0;
    #1;
    check("arst.x", int'($signed(topLeftX)), 256);
    check("arst.y", int'($signed(topLeftY)), 64);
    check("arst.idx", int'(angleIdx), 0);
    check("arst.state", int'(hookState), 0);
    check("arst.returned", int'(hookReturned), 0);
    check("arst.weight", int'(grabbedWeight), 0);
    @(negedge clk);
    resetN = 1'b1;
    @(negedge clk);

    // Weight 1 at idx 0: X step -10>>>1 = -5, Y step 1>>>1 = 0 clamped to 1.
    launch();
    for (int n = 1; n <= 2; n++) fr(1, 256 - 10 * n, 64 + n, 0, 1, 0, 2'd0);
    fr(1, 226, 67, 0, 2, 1, 2'd1);
    for (int m = 1; m <= 2; m++) fr(1, 226 + 5 * m, 67 - m, 0, 2, 0, 2'd0);
    rq.push_back('{x: 256, y: 64, w: 1});
    fr(1, 256, 64, 0, 0, 0, 2'd0);

`ifdef HOOK_PAUSE_EN
    launch();
    for (int n = 1; n <= 2; n++) fr(1, 256 - 10 * n, 64 + n, 0, 1, 0, 2'd0);
    pause = 1'b1;
    for (int n = 1; n <= 9; n++) fr(1, 236, 66, 0, 1, 0, 2'd0);
    fr(1, 236, 66, 0, 2, 1, 2'd1);
    pause = 1'b0;
    fr(1, 241, 65, 0, 2, 0, 2'd0);
    rq.push_back('{x: 256, y: 64, w: 1});
    fr(1, 256, 64, 0, 0, 0, 2'd0);
`endif

    repeat (4) @(negedge clk);
    check("frame_q.left", fq.size(), 0);
    check("ret_q.left", rq.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
